tea_host: RTL
=============

// Module: tea_host
// PURPOSE
//  Initiator-side sequencer for tea_interface. Accepts one {key, block, mode} request over a valid/ready
//  handshake and drives the core's 64-bit bus: key high, key low, then data write. It waits for the core's
//  out_ready and returns the result over a second valid/ready handshake. It sits between a system/bus
//  master and tea_interface. It skips key loading while the core key is known good.
// PARAMETERS
//  TIMEOUT    64  max cycles spent in WAIT before giving up (1..255)
//  TIMEOUT_W  8   width of the wait counter; must hold TIMEOUT
// PORTS
//  clk            in   1    single clock, all logic on posedge
//  reset          in   1    synchronous, active-high
//  req_valid      in   1    request present
//  req_ready      out  1    high only in IDLE; transfer when req_valid && req_ready
//  req_mode       in   1    0 = encrypt, 1 = decrypt
//  req_rekey      in   1    force key reload for this request
//  req_key        in   128  key; [127:64] sent first
//  req_data       in   64   plaintext/ciphertext block
//  rsp_valid      out  1    result present, held until rsp_ready
//  rsp_ready      in   1    consumer accepts result
//  rsp_data       out  64   core result (0 on timeout)
//  rsp_timeout    out  1    qualifies rsp_valid: core never signalled ready
//  core_in        out  64   to tea_interface in
//  core_mode      out  1    to tea_interface mode
//  core_reset     out  1    to tea_interface reset (key-high load strobe)
//  core_write     out  1    to tea_interface write
//  core_out       in   64   from tea_interface out
//  core_out_ready in   1    from tea_interface out_ready
// BEHAVIOUR
//  - Reset: state=IDLE, key_loaded=0, counter=0, and every output is 0 except req_ready=1.
//  - On a req transfer, latch key/data/mode. Next state = KEY_HI if (req_rekey || !key_loaded), else WRITE.
//  - KEY_HI (1 cycle): core_reset=1, core_in=key[127:64], core_write=0.
//  - KEY_LO (1 cycle): core_reset=0, core_in=key[63:0]. Set key_loaded=1 on exit.
//  - WRITE (1 cycle): core_write=1, core_in=data, core_mode=mode. Clear the counter.
//  - WAIT: core_write=0, and core_mode is held at the latched mode.
//    Counter increments each cycle; the counter is TIMEOUT_W wide and saturates at TIMEOUT.
//  - Done = rising edge of core_out_ready (core_out_ready && !rdy_q). rdy_q is registered every cycle in all states.
//    Done is only honoured in WAIT. A level held high from a previous op does not complete the request.
//  - Done in WAIT: rsp_data <= core_out, rsp_timeout <= 0, go RESP.
//  - Counter == TIMEOUT with no edge: rsp_data <= 0, rsp_timeout <= 1, key_loaded <= 0, go RESP.
//    If an edge arrives in the same cycle, Done wins.
//  - RESP: rsp_valid=1. rsp_data and rsp_timeout stay stable until rsp_ready. Then go IDLE and drop rsp_valid.
//    A request may be accepted on the following cycle (1 bubble).
//  - Latency, accept to rsp_valid: 3 + N cycles with key load, 1 + N without; N = WAIT cycles to the edge.
//  - core_* outputs are registered and decoded from the next state: each value appears on the cycle of its state.
//    core_in=0 when not in KEY_HI/KEY_LO/WRITE.
//  - req_valid outside IDLE is ignored; the request must be held by its source.
//  - Reset mid-operation aborts immediately to the reset state.
//    In-flight core results are discarded; the next request reloads the key.
// TESTING
//  1. First request, enc, key=2b02056806144976775d0e266c287843, data=74657374206d652e, rekey=0:
//     -> KEY_HI core_in=2b02056806144976 core_reset=1; KEY_LO core_in=775d0e266c287843; WRITE; rsp_data=775d2a6af6ce9209, rsp_timeout=0.
//  2. Follow-up dec of 775d2a6af6ce9209, same key, rekey=0
//     -> no core_reset pulse; core_write asserted the cycle after accept; rsp_data=74657374206d652e.
//  3. rsp_ready held low 5 cycles after rsp_valid, req_valid=1 throughout
//     -> rsp_data stable, req_ready=0, no second core_write until 1 cycle after rsp_ready.
//  4. TIMEOUT=16, core model never raises out_ready
//     -> rsp_valid with rsp_timeout=1, rsp_data=0 after 16 WAIT cycles; next request (rekey=0) still emits KEY_HI/KEY_LO.
//  5. reset asserted 1 cycle during WAIT, then a stray out_ready pulse
//     -> req_ready=1, rsp_valid=0 next cycle, pulse ignored; next request reloads the key.
//  6. core_out_ready already high when WRITE is entered
//     -> no response until it falls and rises again; result is captured on that edge.

Source files
------------

// File: rtl/tea_host_if.sv
// Bus bundle between a system master, the tea_host sequencer and a tea_interface core.
// slave is the sequencer's view; master is the surrounding environment (requester plus core).
interface tea_host_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_mode;
  logic         req_rekey;
  logic [127:0] req_key;
  logic [63:0]  req_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_data;
  logic         rsp_timeout;
  logic [63:0]  core_in;
  logic         core_mode;
  logic         core_reset;
  logic         core_write;
  logic [63:0]  core_out;
  logic         core_out_ready;

  modport master (
    output req_valid, req_mode, req_rekey, req_key, req_data, rsp_ready,
           core_out, core_out_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout,
           core_in, core_mode, core_reset, core_write
  );

  modport slave (
    input  req_valid, req_mode, req_rekey, req_key, req_data, rsp_ready,
           core_out, core_out_ready,
    output req_ready, rsp_valid, rsp_data, rsp_timeout,
           core_in, core_mode, core_reset, core_write
  );
endinterface

// File: rtl/tea_host.sv
// Initiator-side sequencer for tea_interface: loads the key when needed, writes one block,
// waits for the core's out_ready rising edge (or a timeout) and returns the result.
module tea_host #(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned TIMEOUT_W = 8
) (
  input logic       clk,
  input logic       reset,
  tea_host_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEY_HI = 3'd1,
    S_KEY_LO = 3'd2,
    S_WRITE  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);

  state_e               state_q, state_d;
  logic [127:0]         key_q, key_d;
  logic [63:0]          data_q, data_d;
  logic                 mode_q, mode_d;
  logic                 key_loaded_q, key_loaded_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 rdy_q, rdy_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [63:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic [63:0]          core_in_q, core_in_d;
  logic                 core_mode_q, core_mode_d;
  logic                 core_reset_q, core_reset_d;
  logic                 core_write_q, core_write_d;

  logic                 accept_s;
  logic                 done_s;
  logic [TIMEOUT_W-1:0] cnt_inc_s;
  logic                 timeout_s;

  assign accept_s  = bus.req_valid && req_ready_q;
  // Only a fresh rising edge completes a request; a level left high by a previous op does not.
  assign done_s    = bus.core_out_ready && !rdy_q;
  // cnt_inc_s is the number of WAIT cycles spent including the current one.
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
  assign timeout_s = (cnt_inc_s == CNT_MAX);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      key_q         <= 128'd0;
      data_q        <= 64'd0;
      mode_q        <= 1'b0;
      key_loaded_q  <= 1'b0;
      cnt_q         <= {TIMEOUT_W{1'b0}};
      rdy_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 64'd0;
      rsp_timeout_q <= 1'b0;
      core_in_q     <= 64'd0;
      core_mode_q   <= 1'b0;
      core_reset_q  <= 1'b0;
      core_write_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      data_q        <= data_d;
      mode_q        <= mode_d;
      key_loaded_q  <= key_loaded_d;
      cnt_q         <= cnt_d;
      rdy_q         <= rdy_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      core_in_q     <= core_in_d;
      core_mode_q   <= core_mode_d;
      core_reset_q  <= core_reset_d;
      core_write_q  <= core_write_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = (bus.req_rekey || !key_loaded_q) ? S_KEY_HI : S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_KEY_HI: state_d = S_KEY_LO;
      S_KEY_LO: state_d = S_WRITE;
      S_WRITE:  state_d = S_WAIT;
      S_WAIT: begin
        if (done_s || timeout_s) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates and output decode from the next state.
  always_comb begin
    if (accept_s) begin
      key_d  = bus.req_key;
      data_d = bus.req_data;
      mode_d = bus.req_mode;
    end else begin
      key_d  = key_q;
      data_d = data_q;
      mode_d = mode_q;
    end

    key_loaded_d  = key_loaded_q;
    cnt_d         = cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    rdy_d         = bus.core_out_ready;

    case (state_q)
      S_KEY_LO: key_loaded_d = 1'b1;
      S_WRITE:  cnt_d = {TIMEOUT_W{1'b0}};
      S_WAIT: begin
        cnt_d = cnt_inc_s;
        // An edge in the final WAIT cycle still beats the timeout.
        if (done_s) begin
          rsp_data_d    = bus.core_out;
          rsp_timeout_d = 1'b0;
        end else if (timeout_s) begin
          rsp_data_d    = 64'd0;
          rsp_timeout_d = 1'b1;
          key_loaded_d  = 1'b0;
        end else begin
          rsp_data_d    = rsp_data_q;
          rsp_timeout_d = rsp_timeout_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    rsp_valid_d  = (state_d == S_RESP);
    core_in_d    = 64'd0;
    core_mode_d  = 1'b0;
    core_reset_d = 1'b0;
    core_write_d = 1'b0;

    // key_d/data_d/mode_d already carry the request being accepted this cycle.
    case (state_d)
      S_KEY_HI: begin
        core_reset_d = 1'b1;
        core_in_d    = key_d[127:64];
      end
      S_KEY_LO: core_in_d = key_d[63:0];
      S_WRITE: begin
        core_write_d = 1'b1;
        core_in_d    = data_d;
        core_mode_d  = mode_d;
      end
      S_WAIT:  core_mode_d = mode_d;
      default: core_in_d = 64'd0;
    endcase
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.core_in     = core_in_q;
  assign bus.core_mode   = core_mode_q;
  assign bus.core_reset  = core_reset_q;
  assign bus.core_write  = core_write_q;

endmodule
